mux_scan_reg: RTL and testbench

Parametrised registered multiplexer with a built-in channel scanner: selects one of CHANNELS input words of WIDTH bits, registers it, and drives it through a tri-state output. It extends the combinational 157/153/257/253 selector family with storage (298-style), synchronous strobe-to-zero, and a sequencer that can step through the channels with a programmable dwell. It feeds display multiplexing, sampled status buses and serialised readback paths in the same library.

---
 rtl/mux_scan_reg.sv | 79 +++++++
 tb/tb_mux_scan_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered channel multiplexer with manual select, continuous scan,
// hold and one-shot sweep sequencing, driven out through a tri-state port.
module mux_scan_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*CHANNELS-1:0] a,
    input  logic [SELW-1:0]           sel,
    input  logic [1:0]                mode,
    input  logic                      start,
    input  logic                      str,
    input  logic                      oe,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           ch,
    output logic                      frame,
    output logic                      busy
);
    logic [CHANNELS-1:0][WIDTH-1:0] a_arr;
    logic [WIDTH-1:0] out_d, out_q, cap;
    logic [SELW-1:0] ch_d, ch_q, src;
    logic [15:0] dwell_d, dwell_q;
    logic frame_d, frame_q, busy_d, busy_q, adv, step, wrap;

    assign a_arr = a;

    always_comb begin
        src = (mode == 2'b00) ? sel : ch_q;
        cap = (str || int'(src) >= CHANNELS) ? '0 : a_arr[src];
        adv = (mode == 2'b01) || (mode == 2'b11 && busy_q);
        step = adv && dwell_q == 16'(DWELL - 1);
        // out-of-range channels left by a manual load wrap like the last channel
        wrap = int'(ch_q) >= CHANNELS - 1;
        out_d = out_q;
        ch_d = ch_q;
        dwell_d = dwell_q;
        frame_d = 1'b0;
        busy_d = 1'b0;
        if (mode == 2'b00) begin
            out_d = cap;
            ch_d = sel;
            dwell_d = '0;
        end else if (adv) begin
            out_d = cap;
            dwell_d = step ? '0 : dwell_q + 16'd1;
            ch_d = step ? (wrap ? '0 : ch_q + SELW'(1)) : ch_q;
            frame_d = step && wrap;
            busy_d = (mode == 2'b11) && !(step && wrap);
        end else if (mode == 2'b11 && start) begin
            busy_d = 1'b1;
            ch_d = '0;
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ch_q <= '0;
            dwell_q <= '0;
            frame_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ch_q <= ch_d;
            dwell_q <= dwell_d;
            frame_q <= frame_d;
            busy_q <= busy_d;
        end
    end

    assign out = oe ? 'z : out_q;
    assign ch = ch_q;
    assign frame = frame_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: two instances (4 channels/dwell 1 and 3 channels/dwell 3) share
// stimulus; expected outputs are queued per instance and checked by a monitor.
module tb_mux_scan_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] a = 16'hDCBA;
    logic [1:0] sel = '0, mode = '0;
    logic start = 1'b0, str = 1'b0, oe = 1'b0;
    logic [1:0][3:0] outs;
    logic [1:0][1:0] chs;
    logic [1:0] frames, busys;

    typedef struct packed {
        logic [3:0] out;
        logic [1:0] ch;
        logic frame;
        logic busy;
    } exp_t;

    exp_t q0[$], q1[$];
    int checks = 0, failures = 0;
    int m_out[2], m_ch[2], m_dw[2];
    bit m_busy[2], m_frame[2];
    bit rnd_a = 1'b0;

    always #5 clk = ~clk;

    mux_scan_reg #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u0 (
        .clk(clk), .rst_n(rst_n), .a(a), .sel(sel), .mode(mode), .start(start),
        .str(str), .oe(oe), .out(outs[0]), .ch(chs[0]), .frame(frames[0]), .busy(busys[0])
    );

    mux_scan_reg #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a[11:0]), .sel(sel), .mode(mode), .start(start),
        .str(str), .oe(oe), .out(outs[1]), .ch(chs[1]), .frame(frames[1]), .busy(busys[1])
    );

    function automatic int nch(int d);
        return d == 0 ? 4 : 3;
    endfunction

    function automatic int dwl(int d);
        return d == 0 ? 1 : 3;
    endfunction

    function automatic logic [3:0] capf(int d, int src);
        if (str || src >= nch(d)) return 4'h0;
        return a[src*4 +: 4];
    endfunction

    task automatic chk(string nm, int d, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    // Behavioural reference: one call advances instance d by one clock edge.
    task automatic model(int d);
        int n;
        n = nch(d);
        m_frame[d] = 1'b0;
        if (!rst_n) begin
            m_out[d] = 0; m_ch[d] = 0; m_dw[d] = 0; m_busy[d] = 1'b0;
        end else if (mode == 2'b00) begin
            m_out[d] = int'(capf(d, int'(sel)));
            m_ch[d] = int'(sel);
            m_dw[d] = 0;
            m_busy[d] = 1'b0;
        end else if (mode == 2'b01 || (mode == 2'b11 && m_busy[d])) begin
            m_out[d] = int'(capf(d, m_ch[d]));
            m_dw[d]++;
            if (m_dw[d] == dwl(d)) begin
                m_dw[d] = 0;
                if (m_ch[d] >= n - 1) begin
                    m_ch[d] = 0;
                    m_frame[d] = 1'b1;
                    m_busy[d] = 1'b0;
                end else m_ch[d]++;
            end
            if (mode == 2'b01) m_busy[d] = 1'b0;
        end else if (mode == 2'b10) begin
            m_busy[d] = 1'b0;
        end else if (start) begin
            m_busy[d] = 1'b1;
            m_ch[d] = 0;
            m_dw[d] = 0;
        end
    endtask

    task automatic cyc(bit r, logic [1:0] md, logic [1:0] s, bit st, bit sr, bit o);
        exp_t e;
        @(negedge clk);
        rst_n = r; mode = md; sel = s; start = st; str = sr; oe = o;
        if (rnd_a) a = 16'($urandom);
        if (!r) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("async_rst_out", d, outs[d], o ? 4'bzzzz : 4'h0);
                chk("async_rst_ch", d, {2'b0, chs[d]}, 4'h0);
                chk("async_rst_frame", d, {3'b0, frames[d]}, 4'h0);
                chk("async_rst_busy", d, {3'b0, busys[d]}, 4'h0);
            end
        end
        for (int d = 0; d < 2; d++) begin
            model(d);
            e.out = o ? 4'bzzzz : 4'(m_out[d]);
            e.ch = 2'(m_ch[d]);
            e.frame = m_frame[d];
            e.busy = m_busy[d];
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic cmp(int d, exp_t e);
        chk("out", d, outs[d], e.out);
        chk("ch", d, {2'b0, chs[d]}, {2'b0, e.ch});
        chk("frame", d, {3'b0, frames[d]}, {3'b0, e.frame});
        chk("busy", d, {3'b0, busys[d]}, {3'b0, e.busy});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) cmp(0, q0.pop_front());
            if (q1.size() > 0) cmp(1, q1.pop_front());
        end
    end

    initial begin
        int len;
        logic [1:0] md, s;
        repeat (2) cyc(0, 2'b00, 2'd0, 0, 0, 0);
        cyc(1, 2'b00, 2'd2, 0, 0, 0);
        cyc(1, 2'b00, 2'd2, 0, 1, 0);
        repeat (13) cyc(1, 2'b01, 2'd0, 0, 0, 0);
        repeat (5) cyc(1, 2'b10, 2'd0, 0, 0, 0);
        repeat (4) cyc(1, 2'b01, 2'd0, 0, 0, 0);
        cyc(1, 2'b11, 2'd0, 0, 0, 0);
        cyc(1, 2'b11, 2'd0, 1, 0, 0);
        cyc(1, 2'b11, 2'd0, 1, 0, 0);
        repeat (12) cyc(1, 2'b11, 2'd0, 0, 0, 0);
        cyc(1, 2'b11, 2'd0, 1, 0, 0);
        repeat (10) cyc(1, 2'b11, 2'd0, 0, 0, 0);
        cyc(1, 2'b11, 2'd0, 1, 0, 0);
        repeat (2) cyc(1, 2'b11, 2'd0, 0, 0, 0);
        cyc(0, 2'b11, 2'd0, 0, 0, 0);
        cyc(0, 2'b11, 2'd0, 0, 0, 1);
        repeat (6) cyc(1, 2'b01, 2'd0, 0, 0, 1);
        cyc(1, 2'b01, 2'd0, 0, 0, 0);
        repeat (2) cyc(1, 2'b00, 2'd3, 0, 0, 0);
        repeat (5) cyc(1, 2'b01, 2'd0, 0, 0, 0);
        rnd_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            len = $urandom_range(1, 12);
            md = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            for (int j = 0; j < len; j++)
                cyc($urandom_range(0, 99) != 0, md, s, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
